// File: rtl/div_sequencer.sv
// div_sequencer: multicycle DIV/DIVU unit, restoring divide at one quotient bit per cycle.
// Optional macro DIV_EARLY_TERM_EN skips RUN when |divisor| > |dividend|.
`default_nettype none

module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_signed;
  logic [WIDTH-1:0] r_dvs_mag;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_div_zero;
  logic             w_early;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_diff;
  logic             w_unused_rem_msb;

  assign w_dvd_neg  = r_signed & r_dvd[WIDTH-1];
  assign w_dvs_neg  = r_signed & r_dvs[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? (~r_dvd + 1'b1) : r_dvd;
  assign w_dvs_mag  = w_dvs_neg ? (~r_dvs + 1'b1) : r_dvs;
  assign w_div_zero = (r_dvs == '0);

`ifdef DIV_EARLY_TERM_EN
  assign w_early = (w_dvs_mag > w_dvd_mag);
`else
  assign w_early = 1'b0;
`endif

  // The partial remainder never exceeds the divisor, so its top bit only
  // matters inside the trial subtraction.
  assign w_shifted        = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_diff           = w_shifted - {1'b0, r_dvs_mag};
  assign w_unused_rem_msb = r_rem[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_signed  <= 1'b0;
      r_dvs_mag <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_dvd    <= i_dividend;
            r_dvs    <= i_divisor;
            r_signed <= i_is_signed;
            r_busy   <= 1'b1;
            r_state  <= S_PREP;
          end
        end

        S_PREP: begin
          if (i_flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_dvs_mag <= w_dvs_mag;
            r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg   <= w_dvd_neg;
            r_rem     <= '0;
            r_quo     <= w_dvd_mag;
            r_cnt     <= c_CNT_LAST;
            if (w_div_zero) begin
              r_lo    <= '1;
              r_hi    <= r_dvd;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (w_early) begin
              r_quo   <= '0;
              r_rem   <= {1'b0, w_dvd_mag};
              r_state <= S_FIX;
            end else begin
              r_state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (i_flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (w_diff[WIDTH]) begin
              r_rem <= w_shifted;
              r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end else begin
              r_rem <= w_diff;
              r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end
          end
        end

        S_FIX: begin
          if (i_flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_lo    <= r_q_neg ? (~r_quo + 1'b1) : r_quo;
            r_hi    <= r_r_neg ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
            r_dbz   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // Results are already committed; flush has nothing left to cancel.
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized scoreboard bench for div_sequencer against an arithmetic reference.
`default_nettype none

module tb_div_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             i_start;
  logic             i_is_signed;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             i_flush;
  logic             o_busy;
  logic             o_done;
  logic             o_div_by_zero;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  div_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_is_signed  (i_is_signed),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .i_flush      (i_flush),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_div_by_zero(o_div_by_zero),
    .o_hi         (o_hi),
    .o_lo         (o_lo)
  );

  typedef struct {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             dbz;
    int               lat;
    int               start_cyc;
  } exp_t;

  exp_t             exp_q[$];
  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;
  logic [WIDTH-1:0] m_hi     = '0;
  logic [WIDTH-1:0] m_lo     = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Reference: C-style truncating division on 64-bit integers.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sg);
    exp_t   e;
    longint sa, sb, q, r, ma, mb;
    e.start_cyc = 0;
    if (b == '0) begin
      e.lo  = '1;
      e.hi  = a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      if (sg) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      q     = sa / sb;
      r     = sa % sb;
      e.lo  = q[WIDTH-1:0];
      e.hi  = r[WIDTH-1:0];
      e.dbz = 1'b0;
      ma    = (sa < 0) ? -sa : sa;
      mb    = (sb < 0) ? -sb : sb;
      e.lat = WIDTH + 2;
`ifdef DIV_EARLY_TERM_EN
      if (mb > ma) e.lat = 2;
`endif
    end
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding divide.
  always @(negedge clk) begin
    if (!reset && o_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("lo", o_lo, e.lo);
        check("hi", o_hi, e.hi);
        check("div_by_zero", o_div_by_zero, e.dbz);
        check("latency", cyc - e.start_cyc, e.lat);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (o_busy && n < 200);
    if (o_busy) check("idle_timeout", 1, 0);
  endtask

  // Starts a divide from IDLE; tracked ops get an expected entry on the scoreboard.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sg, input bit track);
    exp_t e;
    wait_idle();
    i_start     = 1'b1;
    i_dividend  = a;
    i_divisor   = b;
    i_is_signed = sg;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1);
    if (track) begin
      e           = model(a, b, sg);
      e.start_cyc = cyc;
      exp_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    logic             sg;
    reset       = 1'b1;
    i_start     = 1'b0;
    i_is_signed = 1'b0;
    i_dividend  = '0;
    i_divisor   = '0;
    i_flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_dbz", o_div_by_zero, 0);
    check("rst_hi", o_hi, 0);
    check("rst_lo", o_lo, 0);

    issue(32'd100, 32'd7, 1'b0, 1'b1);
    issue(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1);
    issue(32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1);
    issue(32'h1234, 32'd0, 1'b0, 1'b1);
    issue(32'd9, 32'd3, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    issue(32'd3, 32'd10, 1'b0, 1'b1);
    issue(32'hFFFF_FFFD, 32'd10, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'd0, 1'b1, 1'b1);

    // Flush mid-RUN: no done, results keep the last committed values.
    issue(32'd50, 32'd5, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    check("flush_busy", o_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("flush_hi_hold", o_hi, m_hi);
    check("flush_lo_hold", o_lo, m_lo);

    // A start raised while busy must be ignored entirely.
    issue(32'd1000, 32'd10, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    i_start    = 1'b1;
    i_dividend = 32'd7;
    i_divisor  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("no_queued_start", o_busy, 0);

    // Reset in the middle of RUN clears everything.
    issue(32'd50, 32'd5, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_dbz", o_div_by_zero, 0);
    check("midrst_hi", o_hi, 0);
    check("midrst_lo", o_lo, 0);
    m_hi = '0;
    m_lo = '0;

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       b = WIDTH'($urandom_range(0, 15));
        1:       b = '0;
        default: b = WIDTH'($urandom);
      endcase
      a  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 20)) : WIDTH'($urandom);
      sg = 1'($urandom_range(0, 1));
      issue(a, b, sg, 1'b1);
    end

    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
